// File: rtl/div_seq_32.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes, one
// quotient bit per clock, then a sign-correction step before the one-cycle done pulse.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;

  // Magnitude taken one bit wider so that the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] neg;
    ext = {v[WIDTH-1], v};
    neg = -ext;
    return ext[WIDTH] ? neg[WIDTH-1:0] : ext[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Trial subtraction on the shifted partial remainder; one spare bit carries the sign.
  always_comb begin
    trial     = {r_reg, q_reg[WIDTH-1]} - {2'b00, d_reg};
    trial_neg = trial[WIDTH+1];
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg       <= mag($signed(dividend));
            d_reg       <= mag($signed(divisor));
            r_reg       <= '0;
            cnt         <= '0;
            q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg       <= dividend[WIDTH-1];
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_reg <= trial_neg ? {r_reg[WIDTH-1:0], q_reg[WIDTH-1]} : trial[WIDTH:0];
          q_reg <= {q_reg[WIDTH-2:0], ~trial_neg};
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          quotient  <= apply_sign(q_reg, q_neg);
          remainder <= apply_sign(r_reg[WIDTH-1:0], r_neg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Bench for div_seq_32: directed corner cases, start/reset timing cases and random
// operands, all compared against a 64-bit arithmetic reference model.
module tb_div_seq_32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor  = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  div_seq_32 #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating signed division computed in 64 bits, so -2^31 / -1 simply wraps.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
      z  = 1'b0;
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    int          bad_busy;
    ref_div(a, b, eq, er, ez);
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    lat      = -1;
    bad_busy = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy !== 1'b1) bad_busy++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
    chk({tag, " busy"}, 32'(bad_busy), 32'd0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
    @(negedge clock);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic        ez;
    int          dones;

    repeat (3) @(negedge clock);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    do_div("100/7", 32'd100, 32'd7);
    do_div("-100/7", -32'sd100, 32'd7);
    do_div("100/-7", 32'd100, -32'sd7);
    do_div("-100/-7", -32'sd100, -32'sd7);
    do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("min/1", 32'h8000_0000, 32'd1);
    do_div("max/max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_div("5/9", 32'd5, 32'd9);
    do_div("1234/0", 32'd1234, 32'd0);
    do_div("8/2", 32'd8, 32'd2);

    // Start re-pulsed mid-operation and in the done cycle must be ignored.
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);
    dones = 0;
    for (int n = 1; n <= 69; n++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
      if (n == 34) begin
        chk("repulse done34", 32'(done), 32'd1);
        chk("repulse q34", quotient, 32'd14);
        chk("repulse r34", remainder, 32'd2);
      end
      if (n == 35) chk("repulse idle35", 32'(busy), 32'd0);
      if (n == 69) begin
        ref_div(32'd1000, -32'sd9, eq, er, ez);
        chk("repulse done69", 32'(done), 32'd1);
        chk("repulse q69", quotient, eq);
        chk("repulse r69", remainder, er);
      end
      start = 1'b0;
      if (n == 5)  begin start = 1'b1; dividend = -32'sd50; divisor = 32'd3;   end
      if (n == 34) begin start = 1'b1; dividend = 32'd77;   divisor = 32'd5;   end
      if (n == 35) begin start = 1'b1; dividend = 32'd1000; divisor = -32'sd9; end
    end
    chk("repulse done count", 32'(dones), 32'd2);

    // Reset in the middle of an operation aborts it without a done pulse.
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    do_div("100/7 after abort", 32'd100, 32'd7);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = (i % 2 == 0) ? 32'd0 : 32'($urandom_range(1, 70000));
      endcase
      do_div($sformatf("rand%0d", i), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq_32.md
# div_seq_32

Sequential 32-bit signed divider for the datapath's DIV instruction. It implements division with the same 32-bit operand and result widths as the carry-lookahead add unit. It runs a restoring shift-subtract loop, one quotient bit per clock. Results go to the LO (quotient) and HI (remainder) registers. The control unit starts it with a single-cycle `start` pulse and stalls until `done`.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is required to be supported.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `start`  in  1  request; accepted only when in IDLE.
- `dividend`  in  32  two's-complement dividend; sampled on the accepting edge only.
- `divisor`  in  32  two's-complement divisor; sampled on the accepting edge only.
- `quotient`  out  32  registered quotient (to LO).
- `remainder`  out  32  registered remainder (to HI).
- `busy`  out  1  high from the cycle after acceptance until `done` falls.
- `done`  out  1  single-cycle completion pulse.
- `div_by_zero`  out  1  registered; valid with `done`, held until next accepted start.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: 32 iterations.
  - FIX: sign correction.
  - DONE: 1 cycle, then back to IDLE.
- Acceptance (IDLE and `start`=1), on that edge:
  - Latch |dividend| into the quotient shift register and |divisor| into the divisor register.
  - Clear the 33-bit partial remainder.
  - Latch `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend).
  - Zero the iteration counter; clear `div_by_zero`.
- Magnitudes are computed in 33 bits. |−2^31| = 0x8000_0000 unsigned, so no overflow occurs internally.
- Divisor = 0 at acceptance: skip CALC and go directly to DONE.
  - quotient = 0xFFFF_FFFF, remainder = dividend (unmodified), `div_by_zero` = 1.
- CALC, once per cycle:
  - Shift {R, Q} left by 1.
  - Compute trial = R − D (33-bit).
  - If trial ≥ 0: R = trial, Q[0] = 1. Otherwise Q[0] = 0.
  - The counter increments; after iteration 31 (counter = 31), go to FIX.
- FIX:
  - quotient = `q_neg` ? −Q : Q.
  - remainder = `r_neg` ? −R[31:0] : R[31:0].
  - Semantics: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow case −2^31 / −1 yields quotient 0x8000_0000 (32-bit wrap) and remainder 0. No flag is raised.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `quotient`/`remainder`/`div_by_zero` hold until the next accepted start.
- `start` while not IDLE: ignored. It is not queued and must be re-asserted after `done`.
- `start` in the DONE cycle: ignored. It is accepted no earlier than the following IDLE cycle.
- Reset values:
  - State IDLE; `busy`=0, `done`=0, `div_by_zero`=0.
  - `quotient`=0, `remainder`=0; internal counter and registers 0.
- Reset mid-operation aborts immediately: the next cycle is IDLE with reset values, and no `done` is produced for the aborted operation.
- Reset has priority over `start` on the same edge.

## Timing
- Let cycle 0 be the cycle in which `start`=1 is sampled in IDLE.
- Normal case:
  - Cycles 1–32: CALC, `busy`=1.
  - Cycle 33: FIX, `busy`=1.
  - Cycle 34: DONE, `done`=1, `busy`=1, results valid.
  - Cycle 35: IDLE, `busy`=0.
  - Total latency: 34 cycles, start to `done`.
- Divide by zero: cycle 1 is DONE (`done`=1, `busy`=1, results valid), cycle 2 is IDLE. Latency: 1 cycle.
- Results are registered outputs and change only on the FIX edge (or the acceptance edge in the divide-by-zero case) and on reset.
- Back-to-back: the earliest next acceptance is cycle 35, so throughput is 1 divide per 35 cycles.

## Test plan
- 100 / 7: `done` exactly at cycle 34; quotient 14, remainder 2, `div_by_zero` 0; `busy` high for cycles 1–34 only.
- Sign combinations, each checked against truncating division:
  - −100 / 7 → quotient −14 (0xFFFF_FFF2), remainder −2 (0xFFFF_FFFE).
  - 100 / −7 → quotient −14, remainder 2.
  - −100 / −7 → quotient 14, remainder −2.
- Extremes:
  - 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0.
  - 0x8000_0000 / 1 → quotient 0x8000_0000, remainder 0.
  - 0x7FFF_FFFF / 0x7FFF_FFFF → quotient 1, remainder 0.
  - 5 / 9 → quotient 0, remainder 5.
- Divide by zero, 1234 / 0: `done` at cycle 1, quotient 0xFFFF_FFFF, remainder 1234, `div_by_zero` 1. A following 8 / 2 clears the flag and gives quotient 4.
- Re-pulse `start` at cycles 5 and 34 with different operands: both ignored, and first-operation results are unchanged. `start` at cycle 35 is accepted, and `done` follows at cycle 69.
- Assert `reset` at cycle 20 of an operation: next cycle `busy`=0, outputs 0, no `done` follows. A fresh 100 / 7 then completes correctly at cycle 34.
